// File: rtl/axi4_pgroup_dispatch_pkg.sv
// Shared types and constants for the pixel-group dispatcher: dispatch modes,
// AXI response codes, FSM states and a width helper.
package axi4_pgroup_dispatch_pkg;

  typedef enum logic {
    MODE_BROADCAST = 1'b0,
    MODE_FRAME     = 1'b1
  } mode_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FRAME_PGNUM_DEF = 2400;

  // Index width for a range of n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_pgroup_dispatch_if.sv
// AXI4 write-channel bundle (AW, W, B) between the frame master and the dispatcher.
// Every channel transfers on a clock edge where valid and ready are both high;
// valid never waits for ready, and payload stays stable while valid is high and ready is low.
interface axi4_pgroup_dispatch_if #(
  parameter int MST_ID_W         = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int TRANS_DATA_LEN_W = 8,
  parameter int DATA_WIDTH       = 256,
  parameter int TRANS_WR_RESP_W  = 2
);
  logic [MST_ID_W-1:0]         awid;
  logic [ADDR_WIDTH-1:0]       awaddr;
  logic [TRANS_DATA_LEN_W-1:0] awlen;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_WIDTH-1:0]       wdata;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  logic [MST_ID_W-1:0]         bid;
  logic [TRANS_WR_RESP_W-1:0]  bresp;
  logic                        bvalid;
  logic                        bready;

  modport master (
    output awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi4_pgroup_dispatch_out_stage.sv
// Registered output stage: one pixel group shared by all channels plus a pending
// mask that each channel clears independently, and per-channel frame-done pulses.
module axi4_pgroup_dispatch_out_stage #(
  parameter int IP_AMT     = 2,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [IP_AMT-1:0]     load_mask,
  input  logic                  load_done,
  input  logic [IP_AMT-1:0]     ready,
  output logic                  stage_free,
  output logic [DATA_WIDTH-1:0] data,
  output logic [IP_AMT-1:0]     valid,
  output logic [IP_AMT-1:0]     frame_done
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [IP_AMT-1:0]     mask_q;
  logic [IP_AMT-1:0]     done_q;
  logic [IP_AMT-1:0]     done_pulse_q;
  logic [IP_AMT-1:0]     drain;

  assign drain      = mask_q & ready;
  assign stage_free = (mask_q & ~ready) == '0;

  // A load is only issued when every pending bit drains this cycle, so the new
  // mask and done flags can simply replace the old ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      mask_q       <= '0;
      done_q       <= '0;
      done_pulse_q <= '0;
    end else begin
      done_pulse_q <= drain & done_q;
      if (load) begin
        data_q <= load_data;
        mask_q <= load_mask;
        done_q <= load_done ? load_mask : '0;
      end else begin
        mask_q <= mask_q & ~ready;
        done_q <= done_q & ~drain;
      end
    end
  end

  assign data       = data_q;
  assign valid      = mask_q;
  assign frame_done = done_pulse_q;

endmodule

// File: rtl/axi4_pgroup_dispatch.sv
// AXI4 write slave that fans pixel-group bursts out to IP_AMT image-processor
// channels, either broadcast or whole frames round-robin.
module axi4_pgroup_dispatch
  import axi4_pgroup_dispatch_pkg::*;
#(
  parameter int IP_AMT           = 2,
  parameter int MST_ID_W         = 3,
  parameter int DATA_WIDTH       = 256,
  parameter int ADDR_WIDTH       = 32,
  parameter int TRANS_DATA_LEN_W = 8,
  parameter int TRANS_WR_RESP_W  = 2,
  parameter int FRAME_PGNUM      = FRAME_PGNUM_DEF
) (
  input  logic                           ACLK_i,
  input  logic                           ARESETn_i,
  axi4_pgroup_dispatch_if.slave          axi,
  input  logic                           mode_i,
  input  logic [IP_AMT-1:0]              pgroup_ready_i,
  output logic [DATA_WIDTH-1:0]          pgroup_o,
  output logic [IP_AMT-1:0]              pgroup_valid_o,
  output logic [IP_AMT-1:0]              frame_done_o,
  output logic [idx_width(IP_AMT)-1:0]   cur_ch_o,
  output logic [ADDR_WIDTH-1:0]          cap_addr,
  output state_e                         dbg_state
);

  localparam int CH_W = idx_width(IP_AMT);
  localparam int FC_W = idx_width(FRAME_PGNUM);

  state_e                      state_q, state_nxt;
  logic [MST_ID_W-1:0]         id_q;
  logic [TRANS_DATA_LEN_W-1:0] len_q;
  logic [TRANS_DATA_LEN_W-1:0] beat_cnt_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        err_q;
  logic [FC_W-1:0]             frame_cnt_q;
  mode_e                       frame_mode_q;
  logic [CH_W-1:0]             cur_ch_q;

  logic                        aw_hs;
  logic                        w_hs;
  logic                        stage_free;
  logic                        frame_wrap;
  logic                        at_len;
  logic                        len_err;
  mode_e                       beat_mode;
  logic [IP_AMT-1:0]           ch_onehot;
  logic [IP_AMT-1:0]           load_mask;

  assign axi.awready = (state_q == ST_IDLE);
  assign axi.wready  = (state_q == ST_DATA) && stage_free;
  assign axi.bvalid  = (state_q == ST_RESP);
  assign axi.bid     = (state_q == ST_RESP) ? id_q : '0;
  assign axi.bresp   = (state_q == ST_RESP) ?
                       TRANS_WR_RESP_W'(err_q ? RESP_SLVERR : RESP_OKAY) : '0;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) state_q <= ST_IDLE;
    else            state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (axi.awvalid)          state_nxt = ST_DATA;
      ST_DATA: if (w_hs && axi.wlast)    state_nxt = ST_RESP;
      ST_RESP: if (axi.bready)           state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // Length errors are only flagged: an early WLAST still closes the burst, and
  // a missing WLAST on beat AWLEN keeps the burst open until WLAST arrives.
  assign at_len  = (beat_cnt_q == len_q);
  assign len_err = at_len ? !axi.wlast : axi.wlast;

  // The mode is latched on the first beat of a frame and holds until it wraps.
  assign beat_mode  = (frame_cnt_q == '0) ? mode_e'(mode_i) : frame_mode_q;
  assign frame_wrap = (frame_cnt_q == FC_W'(FRAME_PGNUM - 1));
  assign ch_onehot  = IP_AMT'(1) << cur_ch_q;
  assign load_mask  = (beat_mode == MODE_FRAME) ? ch_onehot : '1;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      id_q         <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
      frame_mode_q <= MODE_BROADCAST;
      cur_ch_q     <= '0;
    end else begin
      if (aw_hs) begin
        id_q       <= axi.awid;
        len_q      <= axi.awlen;
        addr_q     <= axi.awaddr;
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end
      if (w_hs) begin
        beat_cnt_q   <= beat_cnt_q + 1'b1;
        if (len_err) err_q <= 1'b1;
        frame_cnt_q  <= frame_wrap ? '0 : frame_cnt_q + 1'b1;
        frame_mode_q <= beat_mode;
        if (frame_wrap && beat_mode == MODE_FRAME)
          cur_ch_q <= (cur_ch_q == CH_W'(IP_AMT - 1)) ? '0 : cur_ch_q + 1'b1;
      end
    end
  end

  axi4_pgroup_dispatch_out_stage #(
    .IP_AMT     (IP_AMT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk        (ACLK_i),
    .rst_n      (ARESETn_i),
    .load       (w_hs),
    .load_data  (axi.wdata),
    .load_mask  (load_mask),
    .load_done  (frame_wrap),
    .ready      (pgroup_ready_i),
    .stage_free (stage_free),
    .data       (pgroup_o),
    .valid      (pgroup_valid_o),
    .frame_done (frame_done_o)
  );

  assign cur_ch_o  = cur_ch_q;
  assign cap_addr  = addr_q;
  assign dbg_state = state_q;

endmodule
